// File: rtl/rx_bit_timer.sv
// rx_bit_timer: mid-bit sample strobe generation from a fractional
// clocks-per-bit ratio, resync on data edges, stuffed-bit removal,
// byte framing and saturating per-packet byte counting.
module rx_bit_timer #(
    parameter int PERIOD_NUM    = 25,
    parameter int PERIOD_DEN    = 3,
    parameter int RESYNC_ACC    = 13,
    parameter int BITS_PER_BYTE = 8,
    parameter int MAX_BYTES     = 69,
    parameter int CNT_W         = 7
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             enable_timer,
    input  logic                             clear,
    input  logic                             resync,
    input  logic                             stuff_bit,
    output logic                             sample_strobe,
    output logic                             shift_enable,
    output logic [$clog2(BITS_PER_BYTE)-1:0] bit_index,
    output logic                             byte_complete,
    output logic [CNT_W-1:0]                 byte_count,
    output logic                             byte_overflow
);

    localparam int ACC_W = $clog2(PERIOD_NUM + PERIOD_DEN);
    localparam int BI_W  = $clog2(BITS_PER_BYTE);

    localparam logic [ACC_W-1:0] NUM_C    = ACC_W'(PERIOD_NUM);
    localparam logic [ACC_W-1:0] DEN_C    = ACC_W'(PERIOD_DEN);
    localparam logic [ACC_W-1:0] RESYNC_C = ACC_W'(RESYNC_ACC);
    localparam logic [BI_W-1:0]  LAST_BIT = BI_W'(BITS_PER_BYTE - 1);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_BYTES);

    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [ACC_W-1:0] sum;
    logic             strobe_reg, strobe_next;
    logic [BI_W-1:0]  bit_index_reg, bit_index_next;
    logic             byte_complete_reg, byte_complete_next;
    logic [CNT_W-1:0] byte_count_reg, byte_count_next;
    logic             overflow_reg, overflow_next;

    // A data bit is shifted only on a strobe that is not a stuffed bit.
    assign shift_enable  = strobe_reg & ~stuff_bit;
    assign sample_strobe = strobe_reg;
    assign bit_index     = bit_index_reg;
    assign byte_complete = byte_complete_reg;
    assign byte_count    = byte_count_reg;
    assign byte_overflow = overflow_reg;

    // Next-state: phase accumulator, strobe, bit framing and byte counting.
    always_comb begin
        sum                = acc_reg + DEN_C;
        acc_next           = acc_reg;
        strobe_next        = 1'b0;
        bit_index_next     = bit_index_reg;
        byte_complete_next = 1'b0;
        byte_count_next    = byte_count_reg;
        overflow_next      = overflow_reg;

        if (clear) begin
            // Packet restart: partial byte and all counts are discarded.
            acc_next       = '0;
            bit_index_next = '0;
            byte_count_next = '0;
            overflow_next  = 1'b0;
        end else begin
            // Phase: resync re-centres and suppresses any crossing this cycle.
            if (resync) begin
                acc_next = RESYNC_C;
            end else if (enable_timer) begin
                if (sum >= NUM_C) begin
                    acc_next    = sum - NUM_C;
                    strobe_next = 1'b1;
                end else begin
                    acc_next = sum;
                end
            end

            // Framing follows any valid shift, including a strobe that is
            // finishing its cycle while the timer is paused or resynced.
            if (shift_enable) begin
                if (bit_index_reg == LAST_BIT) begin
                    bit_index_next     = '0;
                    byte_complete_next = 1'b1;
                    if (byte_count_reg < MAX_C) begin
                        byte_count_next = byte_count_reg + 1'b1;
                    end else begin
                        overflow_next = 1'b1;
                    end
                end else begin
                    bit_index_next = bit_index_reg + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            acc_reg           <= '0;
            strobe_reg        <= 1'b0;
            bit_index_reg     <= '0;
            byte_complete_reg <= 1'b0;
            byte_count_reg    <= '0;
            overflow_reg      <= 1'b0;
        end else begin
            acc_reg           <= acc_next;
            strobe_reg        <= strobe_next;
            bit_index_reg     <= bit_index_next;
            byte_complete_reg <= byte_complete_next;
            byte_count_reg    <= byte_count_next;
            overflow_reg      <= overflow_next;
        end
    end

endmodule
